// File: rtl/saes_pkg.sv
// Shared S-AES types, constants and GF(2^4) helpers for the iterative engine.
package saes_pkg;

  typedef enum logic [2:0] {
    StIdle, StKexp1, StKexp2, StRnd0, StRnd1, StRnd2, StDone
  } state_e;

  typedef enum logic [2:0] {
    SelKey1, SelKey2, SelRnd0, SelRnd1, SelRnd2
  } sel_e;

  localparam logic [7:0] RCON1 = 8'h80;
  localparam logic [7:0] RCON2 = 8'h30;

  // Nibble i of the table lives at bits [4*i+3:4*i].
  localparam logic [63:0] SBOX     = 64'h7FEC_3026_581D_BA49;
  localparam logic [63:0] INV_SBOX = 64'hED4C_3206_F871_B95A;

  function automatic logic [3:0] sbox(input logic [3:0] n, input logic inv);
    logic [63:0] tbl;
    tbl = inv ? INV_SBOX : SBOX;
    return tbl[{n, 2'b00} +: 4];
  endfunction

  // Multiply in GF(2^4) modulo x^4 + x + 1.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    p  = 4'h0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

endpackage

// File: rtl/saes_round_dp.sv
// Shared combinational datapath: one S-AES round or one key-expansion step per cycle.
module saes_round_dp
  import saes_pkg::*;
(
  input  logic [15:0] st,
  input  logic [15:0] rk,
  input  logic        mode,
  input  sel_e        sel,
  output logic [15:0] res
);

  function automatic logic [15:0] sub16(input logic [15:0] x, input logic inv);
    return {sbox(x[15:12], inv), sbox(x[11:8], inv), sbox(x[7:4], inv), sbox(x[3:0], inv)};
  endfunction

  function automatic logic [15:0] shift_rows(input logic [15:0] x);
    return {x[15:12], x[3:0], x[7:4], x[11:8]};
  endfunction

  // Forward [1 4; 4 1] or inverse [9 2; 2 9], per byte column.
  function automatic logic [15:0] mix_cols(input logic [15:0] x, input logic inv);
    logic [3:0] m0;
    logic [3:0] m1;
    m0 = inv ? 4'h9 : 4'h1;
    m1 = inv ? 4'h2 : 4'h4;
    return {gf_mul(m0, x[15:12]) ^ gf_mul(m1, x[11:8]),
            gf_mul(m1, x[15:12]) ^ gf_mul(m0, x[11:8]),
            gf_mul(m0, x[7:4])   ^ gf_mul(m1, x[3:0]),
            gf_mul(m1, x[7:4])   ^ gf_mul(m0, x[3:0])};
  endfunction

  function automatic logic [15:0] key_expand(input logic [15:0] k, input logic [7:0] rcon);
    logic [7:0] g;
    logic [7:0] w_hi;
    g    = {sbox(k[3:0], 1'b0), sbox(k[7:4], 1'b0)} ^ rcon;
    w_hi = k[15:8] ^ g;
    return {w_hi, w_hi ^ k[7:0]};
  endfunction

  logic [15:0] sub_sr;

  // Nibble substitution and the nibble swap commute, so both directions share one path.
  always_comb begin
    sub_sr = shift_rows(sub16(st, mode));
    case (sel)
      SelKey1: res = key_expand(rk, RCON1);
      SelKey2: res = key_expand(rk, RCON2);
      SelRnd0: res = st ^ rk;
      SelRnd1: res = mode ? mix_cols(sub_sr ^ rk, 1'b1) : (mix_cols(sub_sr, 1'b0) ^ rk);
      SelRnd2: res = sub_sr ^ rk;
      default: res = st;
    endcase
  end

endmodule

// File: rtl/saes_iter_engine.sv
// Iterative S-AES encrypt/decrypt engine: FSM, key/state registers, key cache, handshakes.
module saes_iter_engine
  import saes_pkg::*;
#(
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [15:0] in_data,
  input  logic [15:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_mode,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [15:0] st_q, st_d;
  logic [15:0] k0_q, k0_d, k1_q, k1_d, k2_q, k2_d;
  logic        mode_q, mode_d;
  logic        cache_vld_q, cache_vld_d;

  sel_e        dp_sel;
  logic [15:0] dp_rk;
  logic [15:0] dp_res;
  logic        hit;

  saes_round_dp u_round_dp (
    .st   (st_q),
    .rk   (dp_rk),
    .mode (mode_q),
    .sel  (dp_sel),
    .res  (dp_res)
  );

  assign hit = KEY_CACHE && cache_vld_q && (in_key == k0_q);

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    k0_d        = k0_q;
    k1_d        = k1_q;
    k2_d        = k2_q;
    mode_d      = mode_q;
    cache_vld_d = cache_vld_q;
    dp_sel      = SelRnd0;
    dp_rk       = k0_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          st_d   = in_data;
          mode_d = in_mode;
          k0_d   = in_key;
          if (hit) begin
            state_d = StRnd0;
          end else begin
            // K1/K2 no longer match K0 until this expansion finishes.
            cache_vld_d = 1'b0;
            state_d     = StKexp1;
          end
        end
      end
      StKexp1: begin
        dp_sel  = SelKey1;
        dp_rk   = k0_q;
        k1_d    = dp_res;
        state_d = StKexp2;
      end
      StKexp2: begin
        dp_sel      = SelKey2;
        dp_rk       = k1_q;
        k2_d        = dp_res;
        cache_vld_d = KEY_CACHE;
        state_d     = StRnd0;
      end
      StRnd0: begin
        dp_sel  = SelRnd0;
        dp_rk   = mode_q ? k2_q : k0_q;
        st_d    = dp_res;
        state_d = StRnd1;
      end
      StRnd1: begin
        dp_sel  = SelRnd1;
        dp_rk   = k1_q;
        st_d    = dp_res;
        state_d = StRnd2;
      end
      StRnd2: begin
        dp_sel  = SelRnd2;
        dp_rk   = mode_q ? k0_q : k2_q;
        st_d    = dp_res;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      st_q        <= 16'h0;
      k0_q        <= 16'h0;
      k1_q        <= 16'h0;
      k2_q        <= 16'h0;
      mode_q      <= 1'b0;
      cache_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      k0_q        <= k0_d;
      k1_q        <= k1_d;
      k2_q        <= k2_d;
      mode_q      <= mode_d;
      cache_vld_q <= cache_vld_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign out_data  = out_valid ? st_q : 16'h0;
  assign out_mode  = out_valid & mode_q;

endmodule

// File: tb/tb_saes_iter_engine.sv
// Bench for saes_iter_engine: known vectors, backpressure, mid-run reset, random round trips.
module tb_saes_iter_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_mode = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic [15:0] in_key = 16'h0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_mode;
  logic        busy;

  always #5 clk = ~clk;

  saes_iter_engine #(.KEY_CACHE(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .busy      (busy)
  );

  typedef struct {
    logic        mode;
    logic [15:0] data;
    logic [15:0] key;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic        m_vld = 1'b0;
  logic [15:0] m_key = 16'h0;

  int sb[16]  = '{9, 4, 10, 11, 13, 1, 8, 5, 6, 2, 0, 3, 12, 14, 15, 7};
  int isb[16] = '{10, 5, 9, 11, 1, 7, 8, 15, 6, 0, 2, 3, 12, 4, 13, 14};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: textbook S-AES on a 2x2 nibble matrix held in an int.
  function automatic int gmul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 4; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
    for (int i = 6; i >= 4; i--) if (((p >> i) & 1) != 0) p = p ^ ('h13 << (i - 4));
    return p;
  endfunction

  function automatic int nib(input int v, input int i);
    return (v >> (12 - 4 * i)) & 15;
  endfunction

  function automatic int sub_all(input int v, input bit inv);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) r = r | ((inv ? isb[nib(v, i)] : sb[nib(v, i)]) << (12 - 4 * i));
    return r;
  endfunction

  function automatic int swap13(input int v);
    return (v & 'hF0F0) | ((v & 'h0F00) >> 8) | ((v & 'h000F) << 8);
  endfunction

  function automatic int mix(input int v, input int a, input int b);
    int r;
    r = 0;
    for (int c = 0; c < 2; c++) begin
      r = r | ((gmul(a, nib(v, 2 * c)) ^ gmul(b, nib(v, 2 * c + 1))) << (12 - 8 * c));
      r = r | ((gmul(b, nib(v, 2 * c)) ^ gmul(a, nib(v, 2 * c + 1))) << (8 - 8 * c));
    end
    return r;
  endfunction

  function automatic logic [15:0] model_crypt(input logic [15:0] d, input logic [15:0] k,
                                              input bit dec);
    int w[6];
    int rk[3];
    int rc[2];
    int v;
    rc[0] = 'h80;
    rc[1] = 'h30;
    w[0] = int'(k[15:8]);
    w[1] = int'(k[7:0]);
    for (int r = 1; r <= 2; r++) begin
      int g;
      g = ((sb[w[2*r-1] & 15] << 4) | sb[w[2*r-1] >> 4]) ^ rc[r-1];
      w[2*r]   = w[2*r-2] ^ g;
      w[2*r+1] = w[2*r] ^ w[2*r-1];
    end
    for (int r = 0; r < 3; r++) rk[r] = (w[2*r] << 8) | w[2*r+1];
    v = int'(d);
    if (!dec) begin
      v = v ^ rk[0];
      v = mix(swap13(sub_all(v, 1'b0)), 1, 4) ^ rk[1];
      v = swap13(sub_all(v, 1'b0)) ^ rk[2];
    end else begin
      v = v ^ rk[2];
      v = mix(sub_all(swap13(v), 1'b1) ^ rk[1], 9, 2);
      v = sub_all(swap13(v), 1'b1) ^ rk[0];
    end
    return 16'(v);
  endfunction

  // Starts and ends on a falling edge with the engine idle; lat counts edges from accept
  // to the edge at which out_valid is first seen high.
  task automatic transact(input logic m, input logic [15:0] d, input logic [15:0] k,
                          input int pre_gap, input int hold, input bit bp_check,
                          input logic [15:0] exp_hold, output logic [15:0] res,
                          output logic rmode, output int lat);
    int n;
    n = 0;
    res = 16'h0;
    rmode = 1'b0;
    repeat (pre_gap) @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_wait", 16'(in_ready), 16'h1);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    in_key   = k;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_key   = 16'($urandom);
    in_mode  = 1'($urandom);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      check("out_valid_timeout", 16'(out_valid), 16'h1);
      return;
    end
    res   = out_data;
    rmode = out_mode;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bp_check) begin
        check("bp_out_valid", 16'(out_valid), 16'h1);
        check("bp_out_data", out_data, exp_hold);
        check("bp_in_ready", 16'(in_ready), 16'h0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    m_vld = 1'b1;
    m_key = k;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 16'(in_ready), 16'h1);
    check({tag, "_out_valid"}, 16'(out_valid), 16'h0);
    check({tag, "_out_data"}, out_data, 16'h0);
    check({tag, "_out_mode"}, 16'(out_mode), 16'h0);
    check({tag, "_busy"}, 16'(busy), 16'h0);
  endtask

  initial begin
    vec_t        vecs[5];
    logic [15:0] res;
    logic [15:0] d;
    logic [15:0] k;
    logic [15:0] c;
    logic        rm;
    int          lat;
    int          exp_lat;

    vecs[0] = '{1'b0, 16'hD728, 16'h4AF5, 16'h24EC, 6};
    vecs[1] = '{1'b0, 16'h6F6B, 16'hA73B, 16'h0738, 6};
    vecs[2] = '{1'b1, 16'h0738, 16'hA73B, 16'h6F6B, 4};
    vecs[3] = '{1'b1, 16'h24EC, 16'h4AF5, 16'hD728, 6};
    vecs[4] = '{1'b0, 16'hD728, 16'h4AF5, 16'h24EC, 4};

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      transact(vecs[i].mode, vecs[i].data, vecs[i].key, 0, 0, 1'b0, 16'h0, res, rm, lat);
      check($sformatf("vec%0d_data", i), res, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), 16'(lat), 16'(vecs[i].lat));
      check($sformatf("vec%0d_mode", i), 16'(rm), 16'(vecs[i].mode));
    end

    // Backpressure: result held for 10 cycles, engine idle right after release.
    transact(1'b0, 16'h6F6B, 16'hA73B, 0, 10, 1'b1, 16'h0738, res, rm, lat);
    check("bp_data", res, 16'h0738);
    check("bp_lat", 16'(lat), 16'd6);
    check("bp_release_in_ready", 16'(in_ready), 16'h1);
    check("bp_release_out_valid", 16'(out_valid), 16'h0);

    // Reset while in RND1 of a cache-hit request.
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = 16'h6F6B;
    in_key   = 16'hA73B;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rnd1_busy", 16'(busy), 16'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_vld = 1'b0;
    check_reset_outputs("midrst");
    transact(1'b0, 16'h6F6B, 16'hA73B, 0, 0, 1'b0, 16'h0, res, rm, lat);
    check("midrst_data", res, 16'h0738);
    check("midrst_lat", 16'(lat), 16'd6);

    for (int i = 0; i < 1000; i++) begin
      d = 16'($urandom);
      k = ($urandom_range(0, 3) == 0) ? m_key : 16'($urandom);
      exp_lat = (m_vld && m_key == k) ? 4 : 6;
      c = model_crypt(d, k, 1'b0);
      transact(1'b0, d, k, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 16'h0, res, rm, lat);
      check("rnd_enc_data", res, c);
      check("rnd_enc_lat", 16'(lat), 16'(exp_lat));
      check("rnd_enc_mode", 16'(rm), 16'h0);
      exp_lat = (m_vld && m_key == k) ? 4 : 6;
      transact(1'b1, c, k, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 16'h0, res, rm, lat);
      check("rnd_dec_data", res, d);
      check("rnd_dec_lat", 16'(lat), 16'(exp_lat));
      check("rnd_dec_mode", 16'(rm), 16'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
